frame_1101_tx: RTL and testbench
================================

FRAME_1101_TX -- requirements
Module: frame_1101_tx

Interface
REQ-001 Parameter: DATA_W, default 8, payload width in bits (legal range 2..16).
REQ-002 Parameter: PARITY_EN, default 1; 1 = even-parity bit appended, 0 = parity slot omitted.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 data_in  input  DATA_W  payload word, sampled only at accept.
REQ-006 valid  input  1  payload offered.
REQ-007 ready  output  1  transmitter can accept; accept = valid && ready at rising clk.
REQ-008 out  output  1  registered serial line bit.
REQ-009 busy  output  1  high while a frame is on the line (any state except IDLE).
REQ-010 present  output  3  current FSM state code (debug).
REQ-011 next  output  3  combinational next-state code (debug).

Function
REQ-012 The block SHALL use an FSM with states IDLE=000, SYNC=001, DATA=010, PAR=011, STOP=100; codes 101..111 SHALL transition to IDLE.
REQ-013 A frame SHALL be: sync word 1,1,0,1; then DATA_W payload bits, MSB first; then even parity bit (if PARITY_EN); then one stop bit 0.
REQ-014 Frame length SHALL be 4+DATA_W+PARITY_EN+1 cycles; first sync bit appears on out in the cycle after the accepting edge.
REQ-015 On accept, data_in SHALL be latched into a shift register and parity computed from the latched value; later changes to data_in SHALL not affect the frame.
REQ-016 A bit counter SHALL count 0..3 in SYNC and 0..DATA_W-1 in DATA, clearing on each state change.
REQ-017 Transitions: IDLE->SYNC on accept; SYNC->DATA after 4th bit; DATA->PAR (PARITY_EN=1) or DATA->STOP (PARITY_EN=0) after last bit; PAR->STOP after 1 cycle; STOP->SYNC on accept, else STOP->IDLE.
REQ-018 Parity bit SHALL make the total number of ones in payload+parity even.
REQ-019 ready SHALL be combinational: high in IDLE and STOP, low otherwise.
REQ-020 valid while ready is low SHALL be ignored; no queuing, no error flag.
REQ-021 Back-to-back accept in STOP SHALL start the next sync word in the immediately following cycle (no idle gap beyond the stop bit).
REQ-022 out SHALL be 0 in IDLE and STOP.

Reset
REQ-023 Assertion of rst (low) SHALL immediately force present=IDLE, out=0, counter=0, shift register=0, regardless of clk.
REQ-024 Reset mid-frame SHALL abort the frame with no completion; after release, out stays 0 and ready=1 until the next accept.
REQ-025 Reset values: out=0, busy=0, ready=1, present=000.

Structure
REQ-026 State codes and the sync constant 4'b1101 SHALL live in shared package frame_tx_pkg, for reuse by the matching detector.
REQ-027 The parallel-in/serial-out register with load, shift and MSB output SHALL be a sub-module frame_tx_shifter; the FSM, counter and parity stay in the top module.

Verification
REQ-028 Reset: rst low at t=0, release at 5 ns -> out=0, ready=1, busy=0, present=000 before the first accept.
REQ-029 Single frame DATA_W=8, PARITY_EN=1, data_in=8'h07 accepted -> out = 1101 00000111 1 0 over 14 cycles, then IDLE.
REQ-030 Back-to-back: valid held high with 8'hA5 then 8'h80 -> 1101 10100101 0 0 then 1101 10000000 1 0, no gap cycle.
REQ-031 Ignore while busy: pulse valid with 8'hFF during DATA of an 8'h07 frame -> frame unchanged, no second frame.
REQ-032 Reset mid-frame: assert rst during DATA bit 3 -> out=0 and present=000 same instant, no further frame bits.
REQ-033 PARITY_EN=0, data_in=8'hFF -> out = 1101 11111111 0 (13 cycles), PAR state never visited.

Source files
------------

// File: rtl/frame_tx_pkg.sv
// Shared definitions for the 1101-framed serial link (transmitter and matching detector).
package frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_SYNC = 3'b001,
        ST_DATA = 3'b010,
        ST_PAR  = 3'b011,
        ST_STOP = 3'b100
    } state_e;

    localparam logic [3:0]  SYNC_WORD = 4'b1101;
    localparam int unsigned SYNC_LEN  = 4;
    // Wide enough for the largest payload index (DATA_W <= 16).
    localparam int unsigned CNT_W     = 4;

endpackage

// File: rtl/frame_tx_shifter.sv
// Parallel-in / serial-out register: load has priority over shift, MSB is presented first.
module frame_tx_shifter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    output logic         msb_o
);

    logic [W-1:0] sreg_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg_q <= '0;
        end else if (load_i) begin
            sreg_q <= data_i;
        end else if (shift_i) begin
            sreg_q <= {sreg_q[W-2:0], 1'b0};
        end
    end

    assign msb_o = sreg_q[W-1];

endmodule

// File: rtl/frame_1101_tx.sv
// Serial frame transmitter: sync word 1101, MSB-first payload, optional even parity, stop bit 0.
module frame_1101_tx
    import frame_tx_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              out,
    output logic              busy,
    output logic [2:0]        present,
    output logic [2:0]        next
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             parity_q;
    logic             accept;
    logic             shift_en;
    logic             sh_msb;

    assign ready  = (state_q == ST_IDLE) || (state_q == ST_STOP);
    assign accept = valid && ready;

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = accept ? ST_SYNC : ST_IDLE;
            ST_SYNC: state_d = (cnt_q == CNT_W'(SYNC_LEN - 1)) ? ST_DATA : ST_SYNC;
            ST_DATA: begin
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = PARITY_EN ? ST_PAR : ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PAR:  state_d = ST_STOP;
            ST_STOP: state_d = accept ? ST_SYNC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && ((state_q == ST_SYNC) || (state_q == ST_DATA))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // out is registered with the bit that belongs to the upcoming state/count,
    // so the shifter advances on the same edge that presents its MSB.
    assign shift_en = (state_d == ST_DATA);

    always_comb begin
        out_d = 1'b0;
        case (state_d)
            ST_SYNC: out_d = SYNC_WORD[2'd3 - cnt_d[1:0]];
            ST_DATA: out_d = sh_msb;
            ST_PAR:  out_d = parity_q;
            default: out_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            if (accept) begin
                parity_q <= ^data_in;
            end
        end
    end

    frame_tx_shifter #(
        .W (DATA_W)
    ) u_shifter (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (accept),
        .shift_i (shift_en),
        .data_i  (data_in),
        .msb_o   (sh_msb)
    );

    assign out     = out_q;
    assign busy    = (state_q != ST_IDLE);
    assign present = state_q;
    assign next    = state_d;

endmodule

// File: tb/tb_frame_1101_tx.sv
// Bench for frame_1101_tx: one parity-enabled and one parity-free instance against a frame-list model.
module tb_frame_1101_tx;

    localparam int unsigned W = 8;

    typedef bit bitq_t[$];

    logic         clk;
    logic         rst;
    logic         vin;
    logic         sel;
    logic [W-1:0] din;

    logic       valid_a, ready_a, out_a, busy_a;
    logic [2:0] present_a, next_a;
    logic       valid_b, ready_b, out_b, busy_b;
    logic [2:0] present_b, next_b;

    logic       obs_out, obs_ready, obs_busy;
    logic [2:0] obs_present, obs_next;

    int total = 0;
    int bad   = 0;

    assign valid_a = vin && !sel;
    assign valid_b = vin && sel;

    assign obs_out     = sel ? out_b     : out_a;
    assign obs_ready   = sel ? ready_b   : ready_a;
    assign obs_busy    = sel ? busy_b    : busy_a;
    assign obs_present = sel ? present_b : present_a;
    assign obs_next    = sel ? next_b    : next_a;

    frame_1101_tx #(.DATA_W(W), .PARITY_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .data_in(din), .valid(valid_a), .ready(ready_a),
        .out(out_a), .busy(busy_a), .present(present_a), .next(next_a)
    );

    frame_1101_tx #(.DATA_W(W), .PARITY_EN(1'b0)) dut_np (
        .clk(clk), .rst(rst), .data_in(din), .valid(valid_b), .ready(ready_b),
        .out(out_b), .busy(busy_b), .present(present_b), .next(next_b)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Reference: the frame as a list of line bits.
    function automatic bitq_t frame_bits(input logic [W-1:0] d, input bit pen);
        bitq_t q;
        q = {1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = W - 1; i >= 0; i--) q.push_back(d[i]);
        if (pen) q.push_back(bit'($countones(d) % 2));
        q.push_back(1'b0);
        return q;
    endfunction

    // Reference: state code expected while line position p of a frame is shown.
    function automatic logic [2:0] state_at(input int p, input bit pen);
        if (p < 4) return 3'b001;
        if (p < 4 + int'(W)) return 3'b010;
        if (pen && p == 4 + int'(W)) return 3'b011;
        return 3'b100;
    endfunction

    task automatic test_reset();
        rst = 1'b0; vin = 1'b0; sel = 1'b0; din = '0;
        #4;
        total++;
        if (out_a !== 1'b0 || present_a !== 3'b000 || ready_a !== 1'b1 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: out=%b present=%b ready=%b busy=%b, want 0 000 1 0",
                     out_a, present_a, ready_a, busy_a);
        end
        #1 rst = 1'b1;
        @(negedge clk);
        total++;
        if (out_a !== 1'b0 || present_a !== 3'b000 || ready_a !== 1'b1 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_a: out=%b present=%b ready=%b busy=%b, want 0 000 1 0",
                     out_a, present_a, ready_a, busy_a);
        end
        total++;
        if (out_b !== 1'b0 || present_b !== 3'b000 || ready_b !== 1'b1 || busy_b !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_b: out=%b present=%b ready=%b busy=%b, want 0 000 1 0",
                     out_b, present_b, ready_b, busy_b);
        end
    endtask

    task automatic test_single(input logic [W-1:0] d);
        bitq_t exp;
        int    len;
        sel = 1'b0;
        exp = frame_bits(d, 1'b1);
        len = exp.size();
        @(negedge clk);
        vin = 1'b1; din = d;
        @(negedge clk);
        vin = 1'b0;
        for (int i = 0; i < len; i++) begin
            total++;
            if (obs_out !== exp[i] || obs_present !== state_at(i, 1'b1) ||
                obs_ready !== (i == len - 1) || obs_busy !== 1'b1) begin
                bad++;
                $display("FAIL single[%0d]: out=%b present=%b ready=%b busy=%b, want %b %b %b 1",
                         i, obs_out, obs_present, obs_ready, obs_busy,
                         exp[i], state_at(i, 1'b1), (i == len - 1));
            end
            @(negedge clk);
        end
        total++;
        if (obs_present !== 3'b000 || obs_out !== 1'b0 || obs_busy !== 1'b0) begin
            bad++;
            $display("FAIL single_end: present=%b out=%b busy=%b, want 000 0 0",
                     obs_present, obs_out, obs_busy);
        end
    endtask

    task automatic test_back_to_back();
        bitq_t exp;
        bitq_t second;
        int    len1;
        sel = 1'b0;
        exp = frame_bits(8'hA5, 1'b1);
        len1 = exp.size();
        second = frame_bits(8'h80, 1'b1);
        foreach (second[k]) exp.push_back(second[k]);
        @(negedge clk);
        vin = 1'b1; din = 8'hA5;
        @(negedge clk);
        din = 8'h80;
        for (int i = 0; i < exp.size(); i++) begin
            if (i == len1) vin = 1'b0;
            total++;
            if (obs_out !== exp[i] || obs_present !== state_at(i % len1, 1'b1)) begin
                bad++;
                $display("FAIL b2b[%0d]: out=%b present=%b, want %b %b",
                         i, obs_out, obs_present, exp[i], state_at(i % len1, 1'b1));
            end
            @(negedge clk);
        end
        total++;
        if (obs_present !== 3'b000 || obs_out !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: present=%b out=%b, want 000 0", obs_present, obs_out);
        end
    endtask

    task automatic test_ignore_busy();
        bitq_t exp;
        sel = 1'b0;
        exp = frame_bits(8'h07, 1'b1);
        @(negedge clk);
        vin = 1'b1; din = 8'h07;
        @(negedge clk);
        vin = 1'b0;
        for (int i = 0; i < exp.size(); i++) begin
            if (i == 6) begin vin = 1'b1; din = 8'hFF; end
            if (i == 7) vin = 1'b0;
            total++;
            if (obs_out !== exp[i]) begin
                bad++;
                $display("FAIL ignore[%0d]: out=%b, want %b", i, obs_out, exp[i]);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs_present !== 3'b000 || obs_out !== 1'b0) begin
                bad++;
                $display("FAIL ignore_idle[%0d]: present=%b out=%b, want 000 0",
                         i, obs_present, obs_out);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        bitq_t exp;
        sel = 1'b0;
        exp = frame_bits(8'h17, 1'b1);
        @(negedge clk);
        vin = 1'b1; din = 8'h17;
        @(negedge clk);
        vin = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (obs_out !== exp[i]) begin
                bad++;
                $display("FAIL rmid_pre[%0d]: out=%b, want %b", i, obs_out, exp[i]);
            end
            if (i < 7) @(negedge clk);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if (obs_out !== 1'b0 || obs_present !== 3'b000 || obs_ready !== 1'b1 || obs_busy !== 1'b0) begin
            bad++;
            $display("FAIL rmid_async: out=%b present=%b ready=%b busy=%b, want 0 000 1 0",
                     obs_out, obs_present, obs_ready, obs_busy);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (obs_out !== 1'b0 || obs_present !== 3'b000 || obs_ready !== 1'b1) begin
                bad++;
                $display("FAIL rmid_after[%0d]: out=%b present=%b ready=%b, want 0 000 1",
                         i, obs_out, obs_present, obs_ready);
            end
        end
    endtask

    task automatic test_noparity();
        bitq_t exp;
        sel = 1'b1;
        exp = frame_bits(8'hFF, 1'b0);
        total++;
        if (exp.size() != 13 + 0 * int'(W)) begin
            bad++;
            $display("FAIL np_len: model=%0d, want 13", exp.size());
        end
        @(negedge clk);
        vin = 1'b1; din = 8'hFF;
        @(negedge clk);
        vin = 1'b0;
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (obs_out !== exp[i] || obs_present === 3'b011 ||
                obs_present !== state_at(i, 1'b0)) begin
                bad++;
                $display("FAIL noparity[%0d]: out=%b present=%b, want %b %b",
                         i, obs_out, obs_present, exp[i], state_at(i, 1'b0));
            end
            @(negedge clk);
        end
        total++;
        if (obs_present !== 3'b000) begin
            bad++;
            $display("FAIL np_end: present=%b, want 000", obs_present);
        end
        sel = 1'b0;
    endtask

    task automatic test_random();
        bitq_t       exp;
        logic [W-1:0] d;
        bit          pen;
        int          len;
        logic [2:0]  want_next;
        for (int k = 0; k < 12; k++) begin
            sel = k[0];
            pen = !sel;
            d = W'($urandom);
            exp = frame_bits(d, pen);
            len = exp.size();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            vin = 1'b1; din = d;
            @(negedge clk);
            vin = 1'b0;
            din = W'($urandom);
            for (int i = 0; i < len; i++) begin
                want_next = (i < len - 1) ? state_at(i + 1, pen) : 3'b000;
                total++;
                if (obs_out !== exp[i] || obs_present !== state_at(i, pen) || obs_next !== want_next) begin
                    bad++;
                    $display("FAIL random[%0d][%0d] d=%h: out=%b present=%b next=%b, want %b %b %b",
                             k, i, d, obs_out, obs_present, obs_next,
                             exp[i], state_at(i, pen), want_next);
                end
                @(negedge clk);
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single(8'h07);
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_noparity();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
